// File: rtl/dag1_pkg.sv
// Shared defaults and the operand-pair type for the DAG1 operand feeder.
package dag1_pkg;

    localparam int BITS_DEFAULT  = 2;
    localparam int DEPTH_DEFAULT = 4;

    // Pair layout at the default width; the feeder re-declares it at its own BITS.
    typedef struct packed {
        logic [BITS_DEFAULT-1:0] a;
        logic [BITS_DEFAULT-1:0] b;
    } pair_t;

endpackage

// File: rtl/dag1_fifo_mem.sv
// Operand-pair storage: DEPTH entries, one synchronous write port, one asynchronous read port.
module dag1_fifo_mem #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    // Contents are deliberately left unreset; occupancy tracking makes them don't-care.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dag1_operand_feeder.sv
// Buffers operand pairs in a small FIFO and presents them through a registered
// output stage to the DAG consumer with valid/ready handshaking.
module dag1_operand_feeder
    import dag1_pkg::*;
#(
    parameter int BITS  = BITS_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BITS-1:0]          in_a,
    input  logic [BITS-1:0]          in_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BITS-1:0]          a_out,
    output logic [BITS-1:0]          b_out,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [BITS-1:0] a;
        logic [BITS-1:0] b;
    } op_pair_t;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    op_pair_t         wr_pair;
    op_pair_t         rd_pair;
    logic             push;
    logic             pop;

    // in_ready looks only at occupancy, so a same-cycle pop never frees a full FIFO.
    assign in_ready = (count < FULL) && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = (!out_valid || out_ready) && (count != '0) && !flush;
    assign wr_pair  = '{a: in_a, b: in_b};

    dag1_fifo_mem #(
        .WIDTH (2 * BITS),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clock   (clock),
        .wr_en   (push && !reset),
        .wr_addr (wr_ptr),
        .wr_data (wr_pair),
        .rd_addr (rd_ptr),
        .rd_data (rd_pair)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
        end else if (flush) begin
            // Flush drops everything in flight but leaves the last operands visible.
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (pop) begin
                out_valid <= 1'b1;
                a_out     <= rd_pair.a;
                b_out     <= rd_pair.b;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dag1_operand_feeder.sv
// Directed bench for dag1_operand_feeder: a vector table for the basic handshake
// paths plus hand-written sequences for streaming, full, flush and reset cases.
module tb_dag1_operand_feeder;

    logic       clock;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_a;
    logic [1:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] a_out;
    logic [1:0] b_out;
    logic [2:0] count;

    int n_cmp = 0;
    int n_bad = 0;

    dag1_operand_feeder #(.BITS(2), .DEPTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out),
        .b_out     (b_out),
        .count     (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       iv;
        logic [1:0] a;
        logic [1:0] b;
        logic       ordy;
        logic       e_ov;
        logic [1:0] e_a;
        logic [1:0] e_b;
        logic [2:0] e_cnt;
        logic       e_ir;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [1:0] a, input logic [1:0] b,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic ov, input logic [1:0] ea,
                           input logic [1:0] eb, input logic [2:0] cnt);
        chk({tag, ".out_valid"}, int'(out_valid), int'(ov));
        chk({tag, ".a_out"}, int'(a_out), int'(ea));
        chk({tag, ".b_out"}, int'(b_out), int'(eb));
        chk({tag, ".count"}, int'(count), int'(cnt));
    endtask

    initial begin
        // iv, a, b, out_ready | out_valid, a_out, b_out, count, in_ready (after the edge)
        vecs[0]  = '{1'b1, 2'd2, 2'd1, 1'b1, 1'b0, 2'd0, 2'd0, 3'd1, 1'b1};
        vecs[1]  = '{1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 2'd2, 2'd1, 3'd0, 1'b1};
        vecs[2]  = '{1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd2, 2'd1, 3'd0, 1'b1};
        vecs[3]  = '{1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 2'd2, 2'd1, 3'd1, 1'b1};
        vecs[4]  = '{1'b1, 2'd1, 2'd1, 1'b0, 1'b1, 2'd0, 2'd0, 3'd1, 1'b1};
        vecs[5]  = '{1'b1, 2'd2, 2'd2, 1'b0, 1'b1, 2'd0, 2'd0, 3'd2, 1'b1};
        vecs[6]  = '{1'b1, 2'd3, 2'd3, 1'b0, 1'b1, 2'd0, 2'd0, 3'd3, 1'b1};
        vecs[7]  = '{1'b1, 2'd0, 2'd1, 1'b0, 1'b1, 2'd0, 2'd0, 3'd4, 1'b0};
        vecs[8]  = '{1'b1, 2'd3, 2'd3, 1'b0, 1'b1, 2'd0, 2'd0, 3'd4, 1'b0};
        vecs[9]  = '{1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 2'd1, 2'd1, 3'd3, 1'b1};
        vecs[10] = '{1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 2'd2, 2'd2, 3'd2, 1'b1};
        vecs[11] = '{1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 2'd3, 2'd3, 3'd1, 1'b1};
        vecs[12] = '{1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 2'd0, 2'd1, 3'd0, 1'b1};
        vecs[13] = '{1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 2'd0, 2'd1, 3'd0, 1'b1};

        reset = 1'b1;
        drive(1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        step();
        step();
        chk_out("reset", 1'b0, 2'd0, 2'd0, 3'd0);
        reset = 1'b0;
        #1;
        chk("reset.in_ready", int'(in_ready), 1);

        // Single pair, then backpressure fill and drain.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].ordy, 1'b0);
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_a, vecs[i].e_b, vecs[i].e_cnt);
            chk($sformatf("vec%0d.in_ready", i), int'(in_ready), int'(vecs[i].e_ir));
        end

        // Streaming 12 pairs through the pointer wrap at full rate.
        for (int c = 0; c < 14; c++) begin
            if (c < 12) drive(1'b1, 2'(c % 4), 2'(3 - (c % 4)), 1'b1, 1'b0);
            else        drive(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
            step();
            chk($sformatf("stream%0d.out_valid", c), int'(out_valid), (c >= 1 && c <= 12) ? 1 : 0);
            chk($sformatf("stream%0d.count", c), int'(count), (c <= 11) ? 1 : 0);
            if (c >= 1 && c <= 12) begin
                chk($sformatf("stream%0d.a_out", c), int'(a_out), (c - 1) % 4);
                chk($sformatf("stream%0d.b_out", c), int'(b_out), 3 - ((c - 1) % 4));
            end
        end

        // Full with simultaneous pop: the push is refused, then accepted next cycle.
        drive(1'b1, 2'd1, 2'd2, 1'b0, 1'b0); step();
        drive(1'b1, 2'd2, 2'd3, 1'b0, 1'b0); step();
        drive(1'b1, 2'd3, 2'd0, 1'b0, 1'b0); step();
        drive(1'b1, 2'd0, 2'd1, 1'b0, 1'b0); step();
        drive(1'b1, 2'd1, 2'd3, 1'b0, 1'b0); step();
        chk_out("full.setup", 1'b1, 2'd1, 2'd2, 3'd4);
        drive(1'b1, 2'd2, 2'd2, 1'b1, 1'b0);
        #1;
        chk("full.in_ready_on_pop", int'(in_ready), 0);
        step();
        chk_out("full.pop", 1'b1, 2'd2, 2'd3, 3'd3);
        drive(1'b1, 2'd2, 2'd2, 1'b0, 1'b0);
        step();
        chk_out("full.push", 1'b1, 2'd2, 2'd3, 3'd4);
        drive(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
        step(); chk_out("full.drain0", 1'b1, 2'd3, 2'd0, 3'd3);
        step(); chk_out("full.drain1", 1'b1, 2'd0, 2'd1, 3'd2);
        step(); chk_out("full.drain2", 1'b1, 2'd1, 2'd3, 3'd1);
        step(); chk_out("full.drain3", 1'b1, 2'd2, 2'd2, 3'd0);
        step(); chk_out("full.drain4", 1'b0, 2'd2, 2'd2, 3'd0);

        // Flush with a pair offered in the same cycle.
        drive(1'b1, 2'd3, 2'd3, 1'b0, 1'b0); step();
        drive(1'b1, 2'd2, 2'd1, 1'b0, 1'b0); step();
        drive(1'b1, 2'd1, 2'd0, 1'b0, 1'b0); step();
        drive(1'b1, 2'd0, 2'd3, 1'b0, 1'b0); step();
        chk_out("flush.setup", 1'b1, 2'd3, 2'd3, 3'd3);
        drive(1'b1, 2'd1, 2'd1, 1'b1, 1'b1);
        #1;
        chk("flush.in_ready", int'(in_ready), 0);
        step();
        chk_out("flush.edge", 1'b0, 2'd3, 2'd3, 3'd0);
        drive(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
        step();
        chk_out("flush.idle", 1'b0, 2'd3, 2'd3, 3'd0);
        drive(1'b1, 2'd2, 2'd0, 1'b1, 1'b0); step();
        drive(1'b0, 2'd0, 2'd0, 1'b1, 1'b0); step();
        chk_out("flush.after", 1'b1, 2'd2, 2'd0, 3'd0);
        step();

        // Reset mid-stream, then a fresh pair through the cleared feeder.
        drive(1'b1, 2'd1, 2'd1, 1'b0, 1'b0); step();
        drive(1'b1, 2'd2, 2'd2, 1'b0, 1'b0); step();
        drive(1'b1, 2'd3, 2'd3, 1'b0, 1'b0); step();
        chk_out("rst.setup", 1'b1, 2'd1, 2'd1, 3'd2);
        reset = 1'b1;
        drive(1'b1, 2'd0, 2'd2, 1'b1, 1'b1);
        step();
        chk_out("rst.edge", 1'b0, 2'd0, 2'd0, 3'd0);
        reset = 1'b0;
        drive(1'b1, 2'd3, 2'd2, 1'b1, 1'b0);
        #1;
        chk("rst.in_ready", int'(in_ready), 1);
        step();
        chk_out("rst.push", 1'b0, 2'd0, 2'd0, 3'd1);
        drive(1'b0, 2'd0, 2'd0, 1'b1, 1'b0);
        step();
        chk_out("rst.out", 1'b1, 2'd3, 2'd2, 3'd0);
        step();
        chk_out("rst.empty", 1'b0, 2'd3, 2'd2, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
